mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//   Consumer end of the EX/MEM pipeline register: takes the EX/MEM control and data fields, runs
//   load/store accesses against a variable-latency data memory over a req/ack handshake, resolves
//   branches, and produces the registered MEM/WB stage fields. Holds the front of the pipeline
//   (stall) while a memory access is outstanding.
// PARAMETERS
//   TIMEOUT  255  max BUSY cycles without dm_ack before entering ERR (1..65535)
// PORTS
//   clk        in   1   single clock, all state on rising edge
//   rst        in   1   asynchronous, active-low reset
//   regwr      in   1   EX/MEM: register write enable
//   memreg     in   1   EX/MEM: write-back select (1 = memory data)
//   memwr      in   1   EX/MEM: store
//   memrd      in   1   EX/MEM: load
//   br         in   1   EX/MEM: branch instruction
//   zr         in   1   EX/MEM: ALU zero flag
//   npc        in   32  EX/MEM: branch target
//   aluout     in   32  EX/MEM: ALU result / memory address
//   reg2       in   32  EX/MEM: store data
//   ir5bit     in   5   EX/MEM: destination register
//   dm_req     out  1   memory request, registered
//   dm_we      out  1   1 = write, registered, valid with dm_req
//   dm_addr    out  32  word address, registered
//   dm_wdata   out  32  store data, registered
//   dm_ack     in   1   memory completion, 1-cycle pulse
//   dm_rdata   in   32  load data, valid when dm_ack=1
//   stall      out  1   combinational; 1 = hold PC, IF/ID, ID/EX, EX/MEM
//   pcsrc      out  1   combinational; 1 = take branch to brtgt this cycle
//   brtgt      out  32  = npc
//   regwro     out  1   MEM/WB register write enable
//   memrego    out  1   MEM/WB write-back select
//   rdatao     out  32  MEM/WB load data
//   aluouto    out  32  MEM/WB ALU result
//   ir5bito    out  5   MEM/WB destination register
//   misal      out  1   1-cycle pulse: misaligned access dropped
//   err        out  1   sticky memory-timeout error
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, timeout counter=0, every output listed above =0.
//   acc = memrd|memwr; memwr wins if both set (treated as store). ok = acc & aluout[1:0]==2'b00.
//   States:
//   - IDLE: ok -> BUSY; at the edge load dm_req=1, dm_we=memwr, dm_addr=aluout, dm_wdata=reg2,
//     cnt=0. acc & !ok -> stay IDLE, retire with regwro=0 and misal=1 for one cycle, no request.
//   - BUSY: dm_req/we/addr/wdata held stable. dm_ack -> IDLE, dm_req=0 at the same edge.
//     Else cnt+1; at cnt==TIMEOUT-1 with no ack -> ERR.
//   - ERR: dm_req=0, err=1 and stall=1 until reset. dm_ack ignored.
//   stall = (IDLE & ok) | (BUSY & !dm_ack) | ERR.
//   retire = !stall. On a retire edge: regwro<=regwr (0 if misaligned), memrego<=memreg,
//   aluouto<=aluout, ir5bito<=ir5bit. rdatao<=dm_rdata for a load acked this cycle, else 0.
//   On a non-retire edge a bubble is inserted: regwro<=0, memrego<=0, other MEM/WB fields hold.
//   pcsrc = br & zr & retire. No memory access is issued for br.
//   Latency: non-memory instruction retires in 1 cycle. Memory op retires in N+1 cycles,
//   where the ack arrives N>=1 cycles after entry. Ack in the first BUSY cycle gives 2 cycles.
//   dm_ack while IDLE: ignored. Reset mid-access: dm_req drops immediately, the access is abandoned.
// TESTING
//   1 ALU op regwr=1, aluout=0x0000_00A5, ir5bit=7 -> next edge regwro=1, aluouto=0xA5, ir5bito=7, stall=0.
//   2 load aluout=0x100, memory ack 3 cycles after req, dm_rdata=0xDEADBEEF -> stall high 3 cycles,
//     dm_addr=0x100, dm_we=0, rdatao=0xDEADBEEF, memrego=1, one bubble (regwro=0) per stalled edge.
//   3 store aluout=0x204, reg2=0x1234_5678, ack in first BUSY cycle -> dm_we=1, dm_wdata=0x12345678,
//     2-cycle occupancy, rdatao=0.
//   4 br=1, zr=1, npc=0x40 -> pcsrc=1, brtgt=0x40 same cycle; repeat with zr=0 -> pcsrc=0.
//   5 load aluout=0x102 -> no dm_req, misal pulses 1 cycle, regwro=0. TIMEOUT=4 with ack never
//     arriving -> ERR after 4 BUSY cycles: err=1, stall=1, dm_req=0.
//   6 rst low during BUSY -> all outputs 0 asynchronously; after release a new load issues normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM stage of the pipeline: issues loads/stores to a variable-latency data memory over a
// req/ack handshake, resolves branches and registers the MEM/WB fields. Stalls the front end while busy.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regwr,
  input  logic        memreg,
  input  logic        memwr,
  input  logic        memrd,
  input  logic        br,
  input  logic        zr,
  input  logic [31:0] npc,
  input  logic [31:0] aluout,
  input  logic [31:0] reg2,
  input  logic [4:0]  ir5bit,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic        pcsrc,
  output logic [31:0] brtgt,
  output logic        regwro,
  output logic        memrego,
  output logic [31:0] rdatao,
  output logic [31:0] aluouto,
  output logic [4:0]  ir5bito,
  output logic        misal,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic        acc, ok;
  logic        issue;
  logic        misal_nx;
  logic        stall_c;
  logic        retire;

  assign acc = memrd | memwr;
  assign ok  = acc & (aluout[1:0] == 2'b00);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    issue    = 1'b0;
    misal_nx = 1'b0;
    stall_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (ok) begin
          state_nx = BUSY;
          cnt_nx   = '0;
          issue    = 1'b1;
          stall_c  = 1'b1;
        end else if (acc) begin
          misal_nx = 1'b1;
        end
      end
      BUSY: begin
        if (dm_ack) begin
          state_nx = IDLE;
        end else begin
          stall_c = 1'b1;
          if (cnt == CNT_LAST) state_nx = ERR;
          else                 cnt_nx   = cnt + 16'd1;
        end
      end
      ERR: begin
        stall_c = 1'b1;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign retire = ~stall_c;

  // Combinational outputs are gated by reset so that everything reads zero while rst is low.
  assign stall = rst & stall_c;
  assign pcsrc = rst & br & zr & retire;
  assign brtgt = rst ? npc : 32'd0;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Request is held for the whole BUSY residency and drops on ack, timeout or reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      err      <= 1'b0;
      misal    <= 1'b0;
    end else begin
      dm_req <= (state_nx == BUSY);
      if (issue) begin
        dm_we    <= memwr;
        dm_addr  <= aluout;
        dm_wdata <= reg2;
      end
      err   <= err | (state_nx == ERR);
      misal <= misal_nx;
    end
  end

  // MEM/WB register: capture on retire, otherwise insert a bubble and hold the data fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwro  <= 1'b0;
      memrego <= 1'b0;
      rdatao  <= '0;
      aluouto <= '0;
      ir5bito <= '0;
    end else if (retire) begin
      regwro  <= regwr & ~misal_nx;
      memrego <= memreg;
      aluouto <= aluout;
      ir5bito <= ir5bit;
      rdatao  <= (state == BUSY && dm_ack && !dm_we) ? dm_rdata : 32'd0;
    end else begin
      regwro  <= 1'b0;
      memrego <= 1'b0;
    end
  end

endmodule
